// File: rtl/axil_dot_slave_if.sv
// AXI4-Lite signal bundle between the accelerator master and the dot-product slave.
interface axil_dot_slave_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_dot_slave.sv
// AXI4-Lite slave for the dot-product accelerator: register file, A/B vector
// buffers and a one-product-per-cycle signed MAC engine.
//
// state  | meaning
// S_IDLE | waiting for a start command; result/done hold
// S_RUN  | accumulating A[idx]*B[idx], one element per cycle
module axil_dot_slave #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic             clk,
  input  logic             rst,
  axil_dot_slave_if.slave  bus,
  output logic             irq
);
  localparam int         IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    R_CTRL, R_STATUS, R_LEN, R_RESLO, R_RESHI, R_VA, R_VB, R_BAD
  } reg_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  function automatic reg_e decode(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] w;
    w = a & ~ADDR_W'(3);
    if (w == ADDR_W'(8'h00))      decode = R_CTRL;
    else if (w == ADDR_W'(8'h04)) decode = R_STATUS;
    else if (w == ADDR_W'(8'h08)) decode = R_LEN;
    else if (w == ADDR_W'(8'h0C)) decode = R_RESLO;
    else if (w == ADDR_W'(8'h10)) decode = R_RESHI;
    else if (w >= ADDR_W'(8'h40) && w < ADDR_W'(64 + 4*DEPTH))  decode = R_VA;
    else if (w >= ADDR_W'(8'h80) && w < ADDR_W'(128 + 4*DEPTH)) decode = R_VB;
    else                          decode = R_BAD;
  endfunction

  state_e            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [4:0]        len_q, len_d;
  logic [63:0]       acc_q, acc_d;
  logic [63:0]       res_q, res_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              aw_full_q, aw_full_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              w_full_q, w_full_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [31:0]       vec_a [DEPTH];
  logic [31:0]       vec_b [DEPTH];

  logic              aw_hs, w_hs, ar_hs, busy, commit;
  logic              ctrl_hit, start_req, clr_req, busy_viol, len_viol, wr_err;
  logic [1:0]        wr_resp;
  reg_e              wr_kind, rd_kind;
  logic [IW-1:0]     wr_idx, rd_idx;
  logic [31:0]       a_cur, b_cur, rd_val;
  logic [1:0]        rd_resp;
  logic [63:0]       prod;

  assign bus.awready = ~aw_full_q & ~bvalid_q;
  assign bus.wready  = ~w_full_q & ~bvalid_q;
  assign bus.arready = ~rvalid_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign irq         = done_q;

  assign aw_hs   = bus.awvalid & bus.awready;
  assign w_hs    = bus.wvalid & bus.wready;
  assign ar_hs   = bus.arvalid & bus.arready;
  assign busy    = (state_q == S_RUN);
  assign commit  = aw_full_q & w_full_q;
  assign wr_kind = decode(awaddr_q);
  assign rd_kind = decode(bus.araddr);
  assign wr_idx  = awaddr_q[IW+1:2];
  assign rd_idx  = bus.araddr[IW+1:2];

  // A CTRL write only acts when its low byte lane is strobed.
  assign ctrl_hit  = commit & (wr_kind == R_CTRL) & wstrb_q[0];
  assign start_req = ctrl_hit & wdata_q[0];
  assign clr_req   = ctrl_hit & wdata_q[1];
  assign busy_viol = commit & busy &
                     (start_req | (wr_kind == R_VA) | (wr_kind == R_VB) | (wr_kind == R_LEN));
  assign len_viol  = start_req & ~busy & (32'(len_q) > DEPTH);
  assign wr_err    = busy_viol | len_viol;
  assign wr_resp   = ((wr_kind == R_BAD) | wr_err) ? SLVERR : OKAY;

  // Full 64-bit sign extension so the low 64 product bits are the signed product.
  assign a_cur = vec_a[idx_q[IW-1:0]];
  assign b_cur = vec_b[idx_q[IW-1:0]];
  assign prod  = {{32{a_cur[31]}}, a_cur} * {{32{b_cur[31]}}, b_cur};

  // Read-side register mux; sees pre-commit values on a same-cycle write.
  always_comb begin
    rd_val  = 32'h0;
    rd_resp = OKAY;
    case (rd_kind)
      R_STATUS: rd_val = {29'h0, err_q, done_q, busy};
      R_LEN:    rd_val = {27'h0, len_q};
      R_RESLO:  rd_val = res_q[31:0];
      R_RESHI:  rd_val = res_q[63:32];
      R_VA:     rd_val = vec_a[rd_idx];
      R_VB:     rd_val = vec_b[rd_idx];
      R_BAD:    rd_resp = SLVERR;
      default:  rd_val = 32'h0;
    endcase
  end

  // AW/W/B and AR/R channel bookkeeping.
  always_comb begin
    awaddr_d  = awaddr_q;
    aw_full_d = aw_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    w_full_d  = w_full_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d  = bus.awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = bus.wdata;
      wstrb_d  = bus.wstrb;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_resp;
    end else if (bvalid_q & bus.bready) begin
      bvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = rd_resp;
    end else if (rvalid_q & bus.rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Control registers and MAC FSM next state; clear is applied before start.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    acc_d   = acc_q;
    res_d   = res_q;
    done_d  = done_q;
    err_d   = err_q;
    if (clr_req) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (wr_err) err_d = 1'b1;
    if (commit & ~busy & (wr_kind == R_LEN) & wstrb_q[0]) len_d = wdata_q[4:0];
    case (state_q)
      S_IDLE: begin
        if (start_req & ~len_viol) begin
          if (len_q == 5'd0) begin
            res_d  = 64'h0;
            done_d = 1'b1;
          end else begin
            acc_d   = 64'h0;
            idx_d   = 5'd0;
            done_d  = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = acc_q + prod;
        idx_d = idx_q + 5'd1;
        if (idx_q == len_q - 5'd1) begin
          res_d   = acc_q + prod;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register for channels, control and FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 5'd0;
      len_q     <= 5'd0;
      acc_q     <= 64'h0;
      res_q     <= 64'h0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      awaddr_q  <= '0;
      aw_full_q <= 1'b0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= OKAY;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      done_q    <= done_d;
      err_q     <= err_d;
      awaddr_q  <= awaddr_d;
      aw_full_q <= aw_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      w_full_q  <= w_full_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Vector buffers: plain storage, byte-lane writes, no reset; locked while busy.
  always_ff @(posedge clk) begin
    if (commit & ~busy & (wr_kind == R_VA)) begin
      for (int k = 0; k < 4; k++)
        if (wstrb_q[k]) vec_a[wr_idx][8*k +: 8] <= wdata_q[8*k +: 8];
    end
    if (commit & ~busy & (wr_kind == R_VB)) begin
      for (int k = 0; k < 4; k++)
        if (wstrb_q[k]) vec_b[wr_idx][8*k +: 8] <= wdata_q[8*k +: 8];
    end
  end
endmodule

// File: tb/tb_axil_dot_slave.sv
// Directed bench for axil_dot_slave: register table plus MAC/handshake sequences.
module tb_axil_dot_slave;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq;

  always #5 clk = ~clk;

  axil_dot_slave_if #(.ADDR_W(ADDR_W)) bus ();

  axil_dot_slave #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .irq (irq)
  );

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  eresp;
    logic [31:0] erdata;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] ma [DEPTH];
  logic [31:0] mb [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_dot(input int len);
    logic [63:0] s = 64'h0;
    for (int i = 0; i < len; i++)
      s = s + {{32{ma[i][31]}}, ma[i]} * {{32{mb[i][31]}}, mb[i]};
    return s;
  endfunction

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int budget = 0;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    while (!(aw_done && w_done) && budget < 50) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge clk); #1; budget++;
      if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  bus.wvalid = 1'b0; end
    end
    while (!bus.bvalid && budget < 50) begin
      @(posedge clk); #1; budget++;
    end
    if (!bus.bvalid) begin
      n_checks++; n_errors++;
      $display("FAIL write_timeout addr=0x%0h", addr);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; resp = 2'b11;
      return;
    end
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int budget = 0;
    bit hs = 0, cur;
    bus.araddr = addr; bus.arvalid = 1'b1;
    while (!hs && budget < 50) begin
      cur = bus.arready;
      @(posedge clk); #1; budget++;
      if (cur) begin hs = 1; bus.arvalid = 1'b0; end
    end
    while (!bus.rvalid && budget < 50) begin
      @(posedge clk); #1; budget++;
    end
    if (!bus.rvalid) begin
      n_checks++; n_errors++;
      $display("FAIL read_timeout addr=0x%0h", addr);
      bus.arvalid = 1'b0; data = 32'hX; resp = 2'b11;
      return;
    end
    data = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic wr_ok(input string name, input logic [7:0] addr, input logic [31:0] data);
    logic [1:0] r;
    axi_write(addr, data, 4'hF, r);
    check(name, r, 2'b00);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    check(name, {r, d}, {2'b00, exp});
  endtask

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b);
    logic [1:0] r;
    axi_write(8'(8'h40 + 4*i), a, 4'hF, r);
    axi_write(8'(8'h80 + 4*i), b, 4'hF, r);
    ma[i] = a; mb[i] = b;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!irq && cycles < 100) begin
      @(posedge clk); #1; cycles++;
    end
    if (!irq) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout irq=%0b", irq);
    end
  endtask

  vec_t tbl [15];

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          cyc;
    bit          stable;

    tbl[0]  = '{1, 8'h08, 32'h4,        4'hF, 2'b00, 32'h0};
    tbl[1]  = '{0, 8'h08, 32'h0,        4'h0, 2'b00, 32'h4};
    tbl[2]  = '{1, 8'h20, 32'h1234,     4'hF, 2'b10, 32'h0};
    tbl[3]  = '{0, 8'hFC, 32'h0,        4'h0, 2'b10, 32'h0};
    tbl[4]  = '{0, 8'h00, 32'h0,        4'h0, 2'b00, 32'h0};
    tbl[5]  = '{1, 8'h40, 32'h11223344, 4'hF, 2'b00, 32'h0};
    tbl[6]  = '{1, 8'h40, 32'hAABBCCDD, 4'h5, 2'b00, 32'h0};
    tbl[7]  = '{0, 8'h40, 32'h0,        4'h0, 2'b00, 32'h11BB33DD};
    tbl[8]  = '{1, 8'hBC, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    tbl[9]  = '{0, 8'hBF, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    tbl[10] = '{1, 8'hC0, 32'h1,        4'hF, 2'b10, 32'h0};
    tbl[11] = '{0, 8'h04, 32'h0,        4'h0, 2'b00, 32'h0};
    tbl[12] = '{1, 8'h08, 32'h1F,       4'h0, 2'b00, 32'h0};
    tbl[13] = '{0, 8'h08, 32'h0,        4'h0, 2'b00, 32'h4};
    tbl[14] = '{0, 8'h0C, 32'h0,        4'h0, 2'b00, 32'h0};

    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check("rst_valids",  {bus.bvalid, bus.rvalid}, 2'b00);
    check("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata}, 36'h0);
    check("rst_irq", irq, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
        check($sformatf("tbl%0d_bresp", i), r, tbl[i].eresp);
      end else begin
        axi_read(tbl[i].addr, d, r);
        check($sformatf("tbl%0d_rresp", i), r, tbl[i].eresp);
        check($sformatf("tbl%0d_rdata", i), d, tbl[i].erdata);
      end
    end

    // LEN=4 basic dot product with exact completion latency
    set_vec(0, 32'd1, 32'd5); set_vec(1, 32'd2, 32'd6);
    set_vec(2, 32'd3, 32'd7); set_vec(3, 32'd4, 32'd8);
    wr_ok("len4_wr", 8'h08, 32'd4);
    wr_ok("start4", 8'h00, 32'h1);
    wait_done(cyc);
    check("len4_latency", cyc, 3);
    check("len4_irq", irq, 1'b1);
    rd_chk("len4_lo", 8'h0C, 32'd70);
    rd_chk("len4_hi", 8'h10, 32'd0);
    rd_chk("len4_status", 8'h04, 32'h2);

    // signed operands and carry into the high word
    set_vec(0, 32'hFFFFFFFD, 32'd2);
    set_vec(1, 32'h7FFFFFFF, 32'h7FFFFFFF);
    wr_ok("len2_wr", 8'h08, 32'd2);
    wr_ok("start2", 8'h00, 32'h1);
    wait_done(cyc);
    rd_chk("len2_lo", 8'h0C, 32'hFFFFFFFB);
    rd_chk("len2_hi", 8'h10, 32'h3FFFFFFE);
    check("len2_model", model_dot(2), 64'h3FFFFFFE_FFFFFFFB);

    // LEN=0 start: immediate done, zero result
    wr_ok("len0_wr", 8'h08, 32'd0);
    wr_ok("start0", 8'h00, 32'h1);
    check("len0_irq", irq, 1'b1);
    rd_chk("len0_lo", 8'h0C, 32'd0);
    rd_chk("len0_hi", 8'h10, 32'd0);

    // W beat three cycles ahead of AW, B held off for four cycles
    bus.wdata = 32'd3; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    check("split_w_ready_drop", {bus.wready, bus.awready}, 2'b01);
    repeat (3) @(posedge clk);
    #1;
    bus.awaddr = 8'h08; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    check("split_aw_ready_drop", bus.awready, 1'b0);
    cyc = 0;
    while (!bus.bvalid && cyc < 10) begin @(posedge clk); #1; cyc++; end
    stable = 1;
    for (int k = 0; k < 4; k++) begin
      if (!(bus.bvalid === 1'b1 && bus.bresp === 2'b00 && bus.awready === 1'b0)) stable = 0;
      @(posedge clk); #1;
    end
    check("split_b_hold", {stable, bus.bvalid, bus.bresp}, {1'b1, 1'b1, 2'b00});
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check("split_after_b", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
    rd_chk("split_len", 8'h08, 32'd3);

    // LEN above DEPTH and clear/start ordering
    wr_ok("len17_wr", 8'h08, 32'd17);
    axi_write(8'h00, 32'h1, 4'hF, r);
    check("len17_start_resp", r, 2'b10);
    rd_chk("len17_status", 8'h04, 32'h6);
    wr_ok("clear", 8'h00, 32'h2);
    rd_chk("clear_status", 8'h04, 32'h0);
    axi_write(8'h00, 32'h3, 4'hF, r);
    check("clr_start_resp", r, 2'b10);
    rd_chk("clr_start_status", 8'h04, 32'h4);
    wr_ok("clear2", 8'h00, 32'h2);

    // full-length run with violations while busy
    for (int i = 0; i < DEPTH; i++) set_vec(i, 32'(i*3 - 20), 32'(i + 1));
    wr_ok("len16_wr", 8'h08, 32'd16);
    wr_ok("start16", 8'h00, 32'h1);
    axi_write(8'h00, 32'h1, 4'hF, r);
    check("busy_start_resp", r, 2'b10);
    axi_write(8'h40, 32'd99, 4'hF, r);
    check("busy_veca_resp", r, 2'b10);
    rd_chk("busy_veca_read", 8'h40, ma[0]);
    rd_chk("busy_status", 8'h04, 32'h5);
    wait_done(cyc);
    rd_chk("len16_lo", 8'h0C, model_dot(16) & 64'hFFFFFFFF);
    rd_chk("len16_hi", 8'h10, model_dot(16) >> 32);
    rd_chk("len16_status", 8'h04, 32'h6);
    wr_ok("clear3", 8'h00, 32'h2);

    // reset in the middle of a run, then restart
    wr_ok("start_rst", 8'h00, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    check("midrst_irq", irq, 1'b0);
    check("midrst_bus", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b11100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rd_chk("midrst_status", 8'h04, 32'h0);
    rd_chk("midrst_len", 8'h08, 32'h0);
    rd_chk("midrst_res", 8'h0C, 32'h0);
    wr_ok("restart_len", 8'h08, 32'd4);
    wr_ok("restart", 8'h00, 32'h1);
    wait_done(cyc);
    rd_chk("restart_lo", 8'h0C, model_dot(4) & 64'hFFFFFFFF);
    rd_chk("restart_hi", 8'h10, model_dot(4) >> 32);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
